lj_pair_coeff_stage: RTL and testbench
======================================

Name: lj_pair_coeff_stage

Overview:
- Pipeline stage between the neighbour pair filter and the LJ force evaluator.
- Accepts filtered particle pair tokens (element codes, r2, neighbour id) over a valid/ready handshake.
- Attaches the LJ force coefficients (coeff_14, coeff_8) for the element pair and buffers the tokens in a small FIFO.
- Lets the force evaluator apply backpressure without stalling the filter combinationally.

Parameters:
- DEPTH, 4, FIFO entries after the lookup register; power of two, minimum 2.
- ID_WIDTH, 8, width of the neighbour/particle id carried with each pair.
- CNT_WIDTH, 16, width of the unknown-pair statistics counter.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- i_pair_valid  in  1  input token valid.
- o_pair_ready  out  1  stage can accept a token this cycle.
- i_elements  in  2*ELEMENT_WIDTH  {elem_a, elem_b} codes; 01=Na, 10=Cl.
- i_r2  in  FLOAT_WIDTH  squared distance, passed through unmodified.
- i_nb_id  in  ID_WIDTH  neighbour id, passed through.
- o_valid  out  1  output token valid.
- i_ready  in  1  force evaluator accepts the token.
- o_r2  out  FLOAT_WIDTH  r2 of the head token.
- o_nb_id  out  ID_WIDTH  id of the head token.
- o_coeff_14  out  FLOAT_WIDTH  r^-14 coefficient of the head token.
- o_coeff_8  out  FLOAT_WIDTH  r^-8 coefficient of the head token.
- o_unknown_cnt  out  CNT_WIDTH  count of accepted pairs with unsupported element codes.

Behaviour:
- Reset (async assert, sync deassert is handled externally):
  - All of the following clear to 0: o_valid, o_r2, o_nb_id, o_coeff_14, o_coeff_8, o_unknown_cnt, s1_valid, FIFO pointers and count.
  - o_pair_ready is 0 while rst_n is low and 1 in the first cycle after release.
- Accept rule: a token is accepted on a rising edge where i_pair_valid && o_pair_ready.
- Lookup (stage 1, registered), taking MD_pkg constants:
  - 4'b0101 → NA_NA_COEFF_14/_8.
  - 4'b0110 or 4'b1001 → NA_CL_COEFF_14/_8.
  - 4'b1010 → CL_CL_COEFF_14/_8.
  - Any other code → both coeffs 0 and the token is flagged unknown.
- Stage 1 holds one token {r2, id, coeff_14, coeff_8, unknown} plus s1_valid.
  - s1_valid moves into the FIFO on the next edge unconditionally; credit flow guarantees space.
- FIFO: DEPTH entries, show-ahead.
  - o_valid = (count != 0); outputs show the head entry.
  - Pop on o_valid && i_ready.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- Credit flow: o_pair_ready = (count + s1_valid) < DEPTH.
  - Computed from registered state only; there is no combinational path from i_ready to o_pair_ready.
  - A pop in the current cycle does not raise ready until the next cycle.
- Latency: with the FIFO empty and i_ready=1, a token accepted at edge N is presented with o_valid=1 after edge N+1 and popped at edge N+2.
  - Throughput: 1 token/cycle while i_ready=1.
- Ordering: strict FIFO order; no token is reordered, duplicated or lost.
- Output hold: while o_valid=1 and i_ready=0, all o_* outputs stay stable.
- Unknown counter: increments at the accept edge of an unknown-code token and saturates at all ones.
- Reset mid-operation clears all tokens in flight; no partial token appears after reset.

Optional Feature:
- Macro: LJ_PAIR_DROP_UNKNOWN_EN.
- Defined: unknown-code tokens are discarded at stage 1 and never written to the FIFO. They consume no FIFO credit beyond their stage-1 cycle and are still counted.
- Not defined: unknown tokens are forwarded with coeff_14 = coeff_8 = 0 (the evaluator produces zero force); the counter still increments.

Test Plan:
- Single pair: elements=4'b0101, r2=32'h3F800000, id=5, i_ready=1 → o_valid high 2 cycles after accept with NA_NA coeffs, r2 and id unchanged; then o_valid=0.
- Symmetry: back-to-back 4'b0110 then 4'b1001 → both outputs carry NA_CL coeffs, in order, on consecutive cycles.
- Backpressure: i_ready=0 and 6 tokens offered → exactly DEPTH=4 accepted, o_pair_ready=0. Outputs stay stable. Raise i_ready → 4 tokens drain in order and ready returns the cycle after the first pop.
- Unknown code: elements=4'b0011 → without the macro, output has zero coeffs and o_unknown_cnt=1. With LJ_PAIR_DROP_UNKNOWN_EN, no output token and o_unknown_cnt=1.
- Counter saturation with CNT_WIDTH=4: 20 unknown tokens → o_unknown_cnt stays at 4'hF.
- Reset mid-stream: assert rst_n=0 with 3 tokens buffered → o_valid=0 immediately, count=0. After release, o_pair_ready=1 and the next token flows with 2-cycle latency.

Source files
------------

// File: rtl/lj_pair_coeff_stage_if.sv
// Bus between the pair filter, lj_pair_coeff_stage and the LJ force evaluator.
// The stage takes the slave view; the filter/evaluator side takes the master view.
interface lj_pair_coeff_stage_if #(
    parameter int ID_WIDTH      = 8,
    parameter int CNT_WIDTH     = 16,
    parameter int FLOAT_WIDTH   = 32,
    parameter int ELEMENT_WIDTH = 2
);
    logic                       i_pair_valid;
    logic                       o_pair_ready;
    logic [2*ELEMENT_WIDTH-1:0] i_elements;
    logic [FLOAT_WIDTH-1:0]     i_r2;
    logic [ID_WIDTH-1:0]        i_nb_id;
    logic                       o_valid;
    logic                       i_ready;
    logic [FLOAT_WIDTH-1:0]     o_r2;
    logic [ID_WIDTH-1:0]        o_nb_id;
    logic [FLOAT_WIDTH-1:0]     o_coeff_14;
    logic [FLOAT_WIDTH-1:0]     o_coeff_8;
    logic [CNT_WIDTH-1:0]       o_unknown_cnt;

    modport slave (
        input  i_pair_valid, i_elements, i_r2, i_nb_id, i_ready,
        output o_pair_ready, o_valid, o_r2, o_nb_id, o_coeff_14, o_coeff_8, o_unknown_cnt
    );

    modport master (
        output i_pair_valid, i_elements, i_r2, i_nb_id, i_ready,
        input  o_pair_ready, o_valid, o_r2, o_nb_id, o_coeff_14, o_coeff_8, o_unknown_cnt
    );
endinterface

// File: rtl/lj_pair_coeff_stage.sv
// LJ pair coefficient stage: registered element-pair coefficient lookup feeding a show-ahead FIFO.
// Define LJ_PAIR_DROP_UNKNOWN_EN to discard unknown element pairs instead of forwarding zero coefficients.
package MD_pkg;
    localparam int ELEMENT_WIDTH = 2;
    localparam int FLOAT_WIDTH   = 32;

    // Normalised LJ force coefficients, IEEE-754 single precision.
    localparam logic [FLOAT_WIDTH-1:0] NA_NA_COEFF_14 = 32'h40C0_0000;
    localparam logic [FLOAT_WIDTH-1:0] NA_NA_COEFF_8  = 32'h4040_0000;
    localparam logic [FLOAT_WIDTH-1:0] NA_CL_COEFF_14 = 32'h4120_0000;
    localparam logic [FLOAT_WIDTH-1:0] NA_CL_COEFF_8  = 32'h40A0_0000;
    localparam logic [FLOAT_WIDTH-1:0] CL_CL_COEFF_14 = 32'h41C0_0000;
    localparam logic [FLOAT_WIDTH-1:0] CL_CL_COEFF_8  = 32'h4140_0000;
endpackage

module lj_pair_coeff_stage
    import MD_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int ID_WIDTH  = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lj_pair_coeff_stage_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [FLOAT_WIDTH-1:0] r2;
        logic [ID_WIDTH-1:0]    id;
        logic [FLOAT_WIDTH-1:0] coeff_14;
        logic [FLOAT_WIDTH-1:0] coeff_8;
    } token_t;

    token_t               look_tok;
    logic                 look_unk;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic                 fifo_valid;
    logic [PTR_W+1:0]     occupancy;

    logic                 s1_valid_q;
    token_t               s1_q;
    token_t               mem_q [DEPTH];
    token_t               head;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]       count_q, count_d;
    logic [CNT_WIDTH-1:0] unk_cnt_q, unk_cnt_d;

    always_comb begin
        look_tok    = '0;
        look_unk    = 1'b0;
        look_tok.r2 = bus.i_r2;
        look_tok.id = bus.i_nb_id;
        case (bus.i_elements)
            4'b0101: begin
                look_tok.coeff_14 = NA_NA_COEFF_14;
                look_tok.coeff_8  = NA_NA_COEFF_8;
            end
            4'b0110, 4'b1001: begin
                look_tok.coeff_14 = NA_CL_COEFF_14;
                look_tok.coeff_8  = NA_CL_COEFF_8;
            end
            4'b1010: begin
                look_tok.coeff_14 = CL_CL_COEFF_14;
                look_tok.coeff_8  = CL_CL_COEFF_8;
            end
            default: look_unk = 1'b1;
        endcase
    end

    // Credit counts the stage-1 token too, so the stage-1 move never finds the FIFO full.
    // Ready depends on registered state only; a pop this cycle frees credit next cycle.
    assign occupancy        = {1'b0, count_q} + (PTR_W+2)'(s1_valid_q);
    assign bus.o_pair_ready = rst_n & (occupancy < (PTR_W+2)'(DEPTH));
    assign accept           = bus.i_pair_valid & bus.o_pair_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) s1_q <= look_tok;
        end
    end

`ifdef LJ_PAIR_DROP_UNKNOWN_EN
    logic s1_unk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      s1_unk_q <= 1'b0;
        else if (accept) s1_unk_q <= look_unk;
    end

    assign push = s1_valid_q & ~s1_unk_q;
`else
    assign push = s1_valid_q;
`endif

    assign fifo_valid = (count_q != '0);
    assign pop        = fifo_valid & bus.i_ready;

    always_comb begin
        // NOTE: combinational logic uses blocking '=' and gives every target a default first, so no latch is inferred.
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        unk_cnt_d = unk_cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: ;
        endcase
        if (accept && look_unk && (unk_cnt_q != '1)) unk_cnt_d = unk_cnt_q + CNT_WIDTH'(1);
    end

    // NOTE: the storage array has no reset; the head outputs are forced to zero while the FIFO is empty instead.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= s1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state is updated with non-blocking '<=' so every register samples pre-edge values.
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            unk_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            unk_cnt_q <= unk_cnt_d;
        end
    end

    assign head              = mem_q[rd_ptr_q];
    assign bus.o_valid       = fifo_valid;
    assign bus.o_r2          = fifo_valid ? head.r2 : '0;
    assign bus.o_nb_id       = fifo_valid ? head.id : '0;
    assign bus.o_coeff_14    = fifo_valid ? head.coeff_14 : '0;
    assign bus.o_coeff_8     = fifo_valid ? head.coeff_8 : '0;
    assign bus.o_unknown_cnt = unk_cnt_q;
endmodule

// File: tb/tb_lj_pair_coeff_stage.sv
// Self-checking bench for lj_pair_coeff_stage: timestamped token-queue model compared every cycle,
// plus directed vectors with hand-computed expectations.
module tb_lj_pair_coeff_stage;
    localparam int DEPTH     = 4;
    localparam int ID_WIDTH  = 8;
    localparam int CNT_WIDTH = 4;
`ifdef LJ_PAIR_DROP_UNKNOWN_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    localparam logic [31:0] NANA14 = 32'h40C0_0000, NANA8 = 32'h4040_0000;
    localparam logic [31:0] NACL14 = 32'h4120_0000, NACL8 = 32'h40A0_0000;
    localparam logic [31:0] CLCL14 = 32'h41C0_0000, CLCL8 = 32'h4140_0000;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    lj_pair_coeff_stage_if #(.ID_WIDTH(ID_WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

    lj_pair_coeff_stage #(.DEPTH(DEPTH), .ID_WIDTH(ID_WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Element-pair table: {unknown, coeff_14, coeff_8}.
    function automatic logic [64:0] lookup(input logic [3:0] e);
        case (e)
            4'b0101:          return {1'b0, NANA14, NANA8};
            4'b0110, 4'b1001: return {1'b0, NACL14, NACL8};
            4'b1010:          return {1'b0, CLCL14, CLCL8};
            default:          return {1'b1, 32'h0, 32'h0};
        endcase
    endfunction

    // Model: every accepted token sits in a queue stamped with the edge index after which it is
    // visible at the output (two edges after acceptance counted from the accept edge itself).
    typedef struct {
        logic [31:0] r2;
        logic [7:0]  id;
        logic [31:0] c14;
        logic [31:0] c8;
        bit          drop;
        int          avail;
    } exp_t;

    exp_t m_q[$];
    int   m_cyc = 0;
    int   m_unk = 0;
    int   m_acc = 0;

    function automatic bit model_valid();
        if (!rst_n || m_q.size() == 0) return 1'b0;
        return !m_q[0].drop && (m_q[0].avail <= m_cyc);
    endfunction

    initial begin : model
        bit          pop_m;
        bit          acc_m;
        logic [64:0] lk;
        exp_t        t;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_q.delete();
                m_unk = 0;
            end else begin
                pop_m = model_valid() && bus.i_ready;
                acc_m = bus.i_pair_valid && (m_q.size() < DEPTH);
                if (pop_m) void'(m_q.pop_front());
                if (acc_m) begin
                    lk      = lookup(bus.i_elements);
                    t.r2    = bus.i_r2;
                    t.id    = bus.i_nb_id;
                    t.c14   = lk[63:32];
                    t.c8    = lk[31:0];
                    t.drop  = DROP && lk[64];
                    t.avail = m_cyc + 2;
                    m_q.push_back(t);
                    m_acc++;
                    if (lk[64] && m_unk < (2**CNT_WIDTH - 1)) m_unk++;
                end
                m_cyc++;
                for (int i = m_q.size() - 1; i >= 0; i--)
                    if (m_q[i].drop && m_q[i].avail <= m_cyc) m_q.delete(i);
            end
        end
    end

    initial begin : compare
        bit ev;
        forever begin
            @(negedge clk);
            ev = model_valid();
            check("cmp_valid", 64'(bus.o_valid), 64'(ev));
            check("cmp_ready", 64'(bus.o_pair_ready), 64'(rst_n && (m_q.size() < DEPTH)));
            check("cmp_unknown_cnt", 64'(bus.o_unknown_cnt), 64'(m_unk));
            if (ev) begin
                check("cmp_r2", 64'(bus.o_r2), 64'(m_q[0].r2));
                check("cmp_nb_id", 64'(bus.o_nb_id), 64'(m_q[0].id));
                check("cmp_coeff_14", 64'(bus.o_coeff_14), 64'(m_q[0].c14));
                check("cmp_coeff_8", 64'(bus.o_coeff_8), 64'(m_q[0].c8));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [3:0] e, input logic [31:0] r2, input logic [7:0] id);
        bus.i_pair_valid = v;
        bus.i_elements   = e;
        bus.i_r2         = r2;
        bus.i_nb_id      = id;
    endtask

    task automatic pin(input string n, input bit v, input logic [31:0] r2, input logic [7:0] id,
                       input logic [31:0] c14, input logic [31:0] c8);
        check({n, "_valid"}, 64'(bus.o_valid), 64'(v));
        if (v) begin
            check({n, "_r2"}, 64'(bus.o_r2), 64'(r2));
            check({n, "_id"}, 64'(bus.o_nb_id), 64'(id));
            check({n, "_c14"}, 64'(bus.o_coeff_14), 64'(c14));
            check({n, "_c8"}, 64'(bus.o_coeff_8), 64'(c8));
        end
    endtask

    logic [3:0] unk_codes [6];
    int         acc_base;

    initial begin : stimulus
        unk_codes = '{4'b0000, 4'b0011, 4'b1111, 4'b1100, 4'b0001, 4'b1000};
        rst_n       = 1'b0;
        bus.i_ready = 1'b1;
        drive(1'b0, 4'b0, 32'h0, 8'h0);

        // Reset state
        @(negedge clk);
        check("rst_ready", 64'(bus.o_pair_ready), 64'd0);
        pin("rst", 1'b0, 32'h0, 8'h0, 32'h0, 32'h0);
        check("rst_r2_zero", 64'(bus.o_r2), 64'd0);
        check("rst_cnt", 64'(bus.o_unknown_cnt), 64'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready", 64'(bus.o_pair_ready), 64'd1);

        // Single pair: visible after the second edge, popped at the third
        step();
        drive(1'b1, 4'b0101, 32'h3F80_0000, 8'd5);
        step();
        drive(1'b0, 4'b0, 32'h0, 8'h0);
        @(negedge clk);
        pin("t1_early", 1'b0, 32'h0, 8'h0, 32'h0, 32'h0);
        step();
        @(negedge clk);
        pin("t1_out", 1'b1, 32'h3F80_0000, 8'd5, NANA14, NANA8);
        step();
        @(negedge clk);
        pin("t1_empty", 1'b0, 32'h0, 8'h0, 32'h0, 32'h0);

        // Symmetry: Na-Cl and Cl-Na back to back
        step();
        drive(1'b1, 4'b0110, 32'h4100_0000, 8'd6);
        step();
        drive(1'b1, 4'b1001, 32'h4110_0000, 8'd7);
        step();
        drive(1'b0, 4'b0, 32'h0, 8'h0);
        @(negedge clk);
        pin("t2_first", 1'b1, 32'h4100_0000, 8'd6, NACL14, NACL8);
        step();
        @(negedge clk);
        pin("t2_second", 1'b1, 32'h4110_0000, 8'd7, NACL14, NACL8);
        step();
        @(negedge clk);
        pin("t2_empty", 1'b0, 32'h0, 8'h0, 32'h0, 32'h0);

        // Backpressure: six offered, only DEPTH accepted, head held stable
        step();
        bus.i_ready = 1'b0;
        acc_base = m_acc;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 4'b1010, 32'h4000_0000 + 32'(i), 8'(10 + i));
            step();
        end
        drive(1'b0, 4'b0, 32'h0, 8'h0);
        check("t3_model_accepted", 64'(m_acc - acc_base), 64'd4);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t3_ready_low", 64'(bus.o_pair_ready), 64'd0);
            pin("t3_hold", 1'b1, 32'h4000_0000, 8'd10, CLCL14, CLCL8);
            step();
        end
        bus.i_ready = 1'b1;
        step();
        @(negedge clk);
        check("t3_ready_back", 64'(bus.o_pair_ready), 64'd1);
        pin("t3_d1", 1'b1, 32'h4000_0001, 8'd11, CLCL14, CLCL8);
        step();
        @(negedge clk);
        pin("t3_d2", 1'b1, 32'h4000_0002, 8'd12, CLCL14, CLCL8);
        step();
        @(negedge clk);
        pin("t3_d3", 1'b1, 32'h4000_0003, 8'd13, CLCL14, CLCL8);
        step();
        @(negedge clk);
        pin("t3_empty", 1'b0, 32'h0, 8'h0, 32'h0, 32'h0);

        // Unknown element code
        step();
        drive(1'b1, 4'b0011, 32'h3F00_0000, 8'd20);
        step();
        drive(1'b0, 4'b0, 32'h0, 8'h0);
        @(negedge clk);
        check("t4_cnt", 64'(bus.o_unknown_cnt), 64'd1);
        step();
        @(negedge clk);
        pin("t4_out", !DROP, 32'h3F00_0000, 8'd20, 32'h0, 32'h0);
        step();

        // Counter saturation: 19 more unknown tokens, 20 in total
        for (int i = 0; i < 19; i++) begin
            drive(1'b1, unk_codes[i % 6], 32'(i), 8'(50 + i));
            step();
        end
        drive(1'b0, 4'b0, 32'h0, 8'h0);
        step();
        step();
        @(negedge clk);
        check("t5_cnt_sat", 64'(bus.o_unknown_cnt), 64'hF);
        pin("t5_empty", 1'b0, 32'h0, 8'h0, 32'h0, 32'h0);

        // Reset mid-stream with three buffered tokens
        step();
        bus.i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'b0101, 32'h4200_0000 + 32'(i), 8'(30 + i));
            step();
        end
        drive(1'b0, 4'b0, 32'h0, 8'h0);
        step();
        @(negedge clk);
        pin("t6_buffered", 1'b1, 32'h4200_0000, 8'd30, NANA14, NANA8);
        step();
        rst_n = 1'b0;
        #1;
        pin("t6_in_reset", 1'b0, 32'h0, 8'h0, 32'h0, 32'h0);
        check("t6_rst_id", 64'(bus.o_nb_id), 64'd0);
        check("t6_rst_ready", 64'(bus.o_pair_ready), 64'd0);
        check("t6_rst_cnt", 64'(bus.o_unknown_cnt), 64'd0);
        step();
        rst_n       = 1'b1;
        bus.i_ready = 1'b1;
        #1;
        check("t6_rel_ready", 64'(bus.o_pair_ready), 64'd1);
        drive(1'b1, 4'b0101, 32'h3F80_0000, 8'd40);
        step();
        drive(1'b0, 4'b0, 32'h0, 8'h0);
        @(negedge clk);
        pin("t6_early", 1'b0, 32'h0, 8'h0, 32'h0, 32'h0);
        step();
        @(negedge clk);
        pin("t6_out", 1'b1, 32'h3F80_0000, 8'd40, NANA14, NANA8);
        step();
        @(negedge clk);
        pin("t6_empty", 1'b0, 32'h0, 8'h0, 32'h0, 32'h0);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
